// File: rtl/mul_div_unit.sv
// RV32M multiply/divide unit: single-cycle multiplies, 33-edge restoring divider.
// Results and the rd tag are registered and announced by a one-cycle DONE pulse.
module mul_div_unit (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [2:0]  OPCODE,
    input  logic [31:0] OPERAND1,
    input  logic [31:0] OPERAND2,
    input  logic [4:0]  DEST_ADDR,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RESULT,
    output logic [4:0]  RESULT_ADDR
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        rem_sel_q, rem_sel_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [4:0]  dest_q, dest_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  result_addr_q, result_addr_d;

    logic        accept_s;
    logic        div_signed_s;
    logic        a_neg_s, b_neg_s;
    logic [31:0] a_mag_s, b_mag_s;
    logic        mul_a_sign_s, mul_b_sign_s;
    logic [63:0] mul_a_s, mul_b_s, prod_s;
    logic [31:0] mul_res_s;
    logic [32:0] rem_sh_s;
    logic        fits_s;
    logic [31:0] quo_fix_s, rem_fix_s;

    function automatic logic [31:0] negate32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    assign accept_s     = START && (state_q == S_IDLE);
    assign div_signed_s = ~OPCODE[0];
    assign a_neg_s      = div_signed_s & OPERAND1[31];
    assign b_neg_s      = div_signed_s & OPERAND2[31];
    assign a_mag_s      = a_neg_s ? negate32(OPERAND1) : OPERAND1;
    assign b_mag_s      = b_neg_s ? negate32(OPERAND2) : OPERAND2;

    // Sign-extend to 64 bits so one unsigned multiply serves every variant.
    assign mul_a_sign_s = ((OPCODE == OP_MULH) || (OPCODE == OP_MULHSU)) & OPERAND1[31];
    assign mul_b_sign_s = (OPCODE == OP_MULH) & OPERAND2[31];
    assign mul_a_s      = {{32{mul_a_sign_s}}, OPERAND1};
    assign mul_b_s      = {{32{mul_b_sign_s}}, OPERAND2};
    assign prod_s       = mul_a_s * mul_b_s;

    // Multiply result select.
    always_comb begin
        mul_res_s = 32'd0;
        case (OPCODE)
            OP_MUL:    mul_res_s = prod_s[31:0];
            OP_MULH:   mul_res_s = prod_s[63:32];
            OP_MULHSU: mul_res_s = prod_s[63:32];
            OP_MULHU:  mul_res_s = prod_s[63:32];
            default:   mul_res_s = 32'd0;
        endcase
    end

    assign rem_sh_s  = {rem_q, quo_q[31]};
    assign fits_s    = (rem_sh_s >= {1'b0, dvsr_q});
    assign quo_fix_s = neg_quo_q ? negate32(quo_q) : quo_q;
    assign rem_fix_s = neg_rem_q ? negate32(rem_q) : rem_q;

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s && OPCODE[2]) begin
                    state_d = S_DIV;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        cnt_d         = cnt_q;
        rem_sel_d     = rem_sel_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        quo_d         = quo_q;
        rem_d         = rem_q;
        dvsr_d        = dvsr_q;
        dest_d        = dest_q;
        done_d        = 1'b0;
        result_d      = result_q;
        result_addr_d = result_addr_q;
        busy_d        = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (accept_s && !OPCODE[2]) begin
                    result_d      = mul_res_s;
                    result_addr_d = DEST_ADDR;
                    done_d        = 1'b1;
                end else if (accept_s) begin
                    cnt_d     = 5'd0;
                    rem_sel_d = OPCODE[1];
                    // A zero divisor leaves an all-ones quotient, which must not be negated;
                    // the remainder naturally reconstructs the dividend.
                    neg_quo_d = (a_neg_s ^ b_neg_s) && (OPERAND2 != 32'd0);
                    neg_rem_d = a_neg_s;
                    quo_d     = a_mag_s;
                    rem_d     = 32'd0;
                    dvsr_d    = b_mag_s;
                    dest_d    = DEST_ADDR;
                end else begin
                    done_d = 1'b0;
                end
            end
            S_DIV: begin
                cnt_d = cnt_q + 5'd1;
                quo_d = {quo_q[30:0], fits_s};
                if (fits_s) begin
                    rem_d = rem_sh_s[31:0] - dvsr_q;
                end else begin
                    rem_d = rem_sh_s[31:0];
                end
            end
            S_FIX: begin
                result_d      = rem_sel_q ? rem_fix_s : quo_fix_s;
                result_addr_d = dest_q;
                done_d        = 1'b1;
            end
            default: begin
                cnt_d = 5'd0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q         <= 5'd0;
            rem_sel_q     <= 1'b0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            quo_q         <= 32'd0;
            rem_q         <= 32'd0;
            dvsr_q        <= 32'd0;
            dest_q        <= 5'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            result_q      <= 32'd0;
            result_addr_q <= 5'd0;
        end else begin
            cnt_q         <= cnt_d;
            rem_sel_q     <= rem_sel_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            quo_q         <= quo_d;
            rem_q         <= rem_d;
            dvsr_q        <= dvsr_d;
            dest_q        <= dest_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            result_q      <= result_d;
            result_addr_q <= result_addr_d;
        end
    end

    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign RESULT      = result_q;
    assign RESULT_ADDR = result_addr_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed, table-driven bench for mul_div_unit plus hand-written sequences
// for ignored START, back-to-back issue and reset abort.
module tb_mul_div_unit;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic [2:0]  OPCODE;
    logic [31:0] OPERAND1;
    logic [31:0] OPERAND2;
    logic [4:0]  DEST_ADDR;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;
    logic [4:0]  RESULT_ADDR;

    int checks;
    int errors;

    mul_div_unit dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .START       (START),
        .OPCODE      (OPCODE),
        .OPERAND1    (OPERAND1),
        .OPERAND2    (OPERAND2),
        .DEST_ADDR   (DEST_ADDR),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .RESULT      (RESULT),
        .RESULT_ADDR (RESULT_ADDR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge: presents a request for one edge, then scrambles inputs.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        START     = 1'b1;
        OPCODE    = op;
        OPERAND1  = a;
        OPERAND2  = b;
        DEST_ADDR = rd;
        @(posedge CLK);
        #1;
        START     = 1'b0;
        OPCODE    = ~op;
        OPERAND1  = 32'hDEAD_BEEF;
        OPERAND2  = 32'h0000_0003;
        DEST_ADDR = ~rd;
    endtask

    // Counts negedges after the accepting edge until DONE; lat stays 0 on timeout.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (DONE) begin
                lat = i;
                break;
            end
            if (BUSY) busy_cnt++;
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int dones;
        checks = 0;
        errors = 0;

        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
        vecs[1]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000};
        vecs[2]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFF};
        vecs[3]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFE};
        vecs[4]  = '{3'b000, 32'h1234_5678, 32'h0000_0010, 5'd0,  32'h2345_6780};
        vecs[5]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd31, 32'hFFFF_FFFF};
        vecs[6]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFD};
        vecs[7]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 32'hFFFF_FFFF};
        vecs[8]  = '{3'b101, 32'd100,       32'd7,         5'd12, 32'd14};
        vecs[9]  = '{3'b111, 32'd100,       32'd7,         5'd13, 32'd2};
        vecs[10] = '{3'b101, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF};
        vecs[11] = '{3'b110, 32'd5,         32'd0,         5'd15, 32'd5};
        vecs[12] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000};
        vecs[13] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000};
        vecs[14] = '{3'b100, 32'hFFFF_FFF9, 32'd0,         5'd18, 32'hFFFF_FFFF};
        vecs[15] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 5'd0,  32'd1};

        RESET     = 1'b1;
        START     = 1'b0;
        OPCODE    = 3'b000;
        OPERAND1  = 32'd0;
        OPERAND2  = 32'd0;
        DEST_ADDR = 5'd0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("reset_busy", {31'd0, BUSY}, 32'd0);
        check("reset_done", {31'd0, DONE}, 32'd0);
        check("reset_result", RESULT, 32'd0);
        check("reset_addr", {27'd0, RESULT_ADDR}, 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
            wait_done(lat, bcnt);
            check($sformatf("v%0d_latency", i), lat, vecs[i].op[2] ? 32'd34 : 32'd1);
            check($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].op[2] ? 32'd33 : 32'd0);
            check($sformatf("v%0d_busy_at_done", i), {31'd0, BUSY}, 32'd0);
            check($sformatf("v%0d_result", i), RESULT, vecs[i].exp);
            check($sformatf("v%0d_addr", i), {27'd0, RESULT_ADDR}, {27'd0, vecs[i].rd});
        end

        // Result must hold while idle.
        repeat (3) @(negedge CLK);
        check("hold_result", RESULT, 32'd1);
        check("hold_done", {31'd0, DONE}, 32'd0);

        // START at E10 of a divide is ignored.
        issue(3'b101, 32'd100, 32'd7, 5'd3);
        repeat (9) @(posedge CLK);
        #1;
        START     = 1'b1;
        OPCODE    = 3'b000;
        OPERAND1  = 32'd9;
        OPERAND2  = 32'd9;
        DEST_ADDR = 5'd20;
        @(posedge CLK);
        #1;
        START = 1'b0;
        wait_done(lat, bcnt);
        check("ignore_latency", lat + 10, 32'd34);
        check("ignore_result", RESULT, 32'd14);
        check("ignore_addr", {27'd0, RESULT_ADDR}, 32'd3);
        @(negedge CLK);
        check("ignore_no_extra_done", {31'd0, DONE}, 32'd0);

        // START in the DONE cycle starts a second divide.
        issue(3'b101, 32'd100, 32'd7, 5'd1);
        wait_done(lat, bcnt);
        check("b2b_first_result", RESULT, 32'd14);
        issue(3'b111, 32'd100, 32'd7, 5'd2);
        wait_done(lat, bcnt);
        check("b2b_second_gap", lat, 32'd34);
        check("b2b_second_result", RESULT, 32'd2);
        check("b2b_second_addr", {27'd0, RESULT_ADDR}, 32'd2);

        // Reset at E15 aborts a divide.
        issue(3'b100, 32'd100, 32'd7, 5'd4);
        repeat (14) @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        check("abort_busy", {31'd0, BUSY}, 32'd0);
        check("abort_done", {31'd0, DONE}, 32'd0);
        check("abort_result", RESULT, 32'd0);
        check("abort_addr", {27'd0, RESULT_ADDR}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (DONE) dones++;
        end
        check("abort_no_done", dones, 32'd0);
        issue(3'b011, 32'd2, 32'd3, 5'd9);
        wait_done(lat, bcnt);
        check("post_reset_latency", lat, 32'd1);
        check("post_reset_result", RESULT, 32'd0);
        check("post_reset_addr", {27'd0, RESULT_ADDR}, 32'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
